prf_bypass: RTL and testbench
=============================

# prf_bypass

Parametrised physical register file for the out-of-order backend. It replaces the plain multi-port register file with:
- same-cycle write-to-read bypass,
- a per-register ready scoreboard driven by rename allocation and writeback,
- fixed write-port priority with conflict reporting,
- an optional registered read stage.

It sits between rename/issue (allocation, operand reads) and the execution units (ALU, FPU, BRU, LSU writeback, NZCV writeback).

## Interface
- WORD_SIZE, 64: register data width.
- NUM_PHYS_REGS, 128: physical registers; IDX_W = $clog2(NUM_PHYS_REGS).
- NUM_READ_PORTS, 4: operand read ports.
- NUM_WRITE_PORTS, 8: writeback ports.
- NUM_ALLOC_PORTS, 2: rename allocation ports.
- READ_LATENCY, 0: 0 = combinational read, 1 = registered read; any other value is an elaboration error.
- CNT_W, 16: conflict counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  NUM_READ_PORTS  per-port read enable.
- rd_index  in  NUM_READ_PORTS x IDX_W  read register index.
- rd_data  out  NUM_READ_PORTS x WORD_SIZE  read data.
- rd_ready  out  NUM_READ_PORTS  scoreboard ready bit of the read register.
- rd_valid  out  NUM_READ_PORTS  read result valid.
- wr_en  in  NUM_WRITE_PORTS  writeback enable.
- wr_index  in  NUM_WRITE_PORTS x IDX_W  writeback index.
- wr_data  in  NUM_WRITE_PORTS x WORD_SIZE  writeback data.
- nzcv_valid  in  1  NZCV flag write.
- nzcv_index  in  IDX_W  NZCV destination register.
- nzcv_data  in  4  N,Z,C,V; stored zero-extended into bits [3:0].
- alloc_en  in  NUM_ALLOC_PORTS  rename allocates a register; the register becomes not ready.
- alloc_index  in  NUM_ALLOC_PORTS x IDX_W  allocated index.
- wr_conflict  out  1  pulse: two or more write sources target the same index this cycle.
- conflict_count  out  CNT_W  saturating count of conflict cycles.

## Operation
- Storage is `regs[NUM_PHYS_REGS]` plus `ready[NUM_PHYS_REGS]`.
- **Write resolution, per index, per cycle.** The highest-priority active source wins; losers are dropped. Priority: NZCV > wr port NUM_WRITE_PORTS-1 > … > wr port 0.
- **Conflict.** `wr_conflict` = 1 when any index has two or more active write sources (NZCV included). `conflict_count` increments by 1 per conflict cycle and saturates at 2^CNT_W-1.
- **Ready scoreboard.**
  - A write (any source) sets `ready[idx]` = 1.
  - An allocation clears `ready[idx]` = 0.
  - Allocation and write to the same index in the same cycle: the allocation wins (ready = 0), because the new producer supersedes the old one. Data is still written.
  - Duplicate allocation indices in one cycle are harmless.
- **Bypass, READ_LATENCY=0.**
  - rd_en=1: `rd_data` = winning same-cycle write data to `rd_index` if one exists, else `regs[rd_index]`.
  - `rd_ready` = 1 if any write to `rd_index` is active this cycle, else `ready[rd_index]`. Same-cycle allocation to that index does not affect `rd_ready` until the next cycle.
  - `rd_valid` = `rd_en`.
  - rd_en=0: `rd_data`=0, `rd_ready`=0, `rd_valid`=0.
- **READ_LATENCY=1.** The same bypassed values are computed in the request cycle and registered. `rd_data`, `rd_ready` and `rd_valid` appear on the following cycle. There is no back-pressure.
- **Reset.**
  - All `regs` = 0 and all `ready` = 1.
  - `rd_data`, `rd_ready`, `rd_valid`, `wr_conflict` = 0 and `conflict_count` = 0.
  - Writes, allocations and reads presented during reset are ignored. The registered read stage holds 0 in the cycle after reset.
  - Reset asserted mid-operation discards any in-flight registered read.

## Timing
- Write: data is visible in `regs` from the cycle after the edge. A same-cycle read sees it via bypass (0-cycle read-after-write).
- Allocation: `ready` = 0 is visible on the cycle after `alloc_en`.
- `wr_conflict` is registered: it asserts the cycle after the conflicting writes, with `conflict_count` updated on the same edge.
- Read latency is 0 or 1 cycle per READ_LATENCY. Throughput is one read per port per cycle.
- All outputs are driven by registers or by combinational logic from registers and inputs. There are no combinational loops.

## Test plan
- **Reset/defaults.** After rst, read idx 5 → rd_data=0, rd_ready=1, conflict_count=0.
- **Bypass.** Port 2 writes 0xDEAD_BEEF to idx 7 while port 0 reads idx 7 in the same cycle → rd_data=0xDEAD_BEEF, rd_ready=1 (READ_LATENCY=0). With READ_LATENCY=1, the same values appear one cycle later.
- **Priority.**
  - Same cycle: port 1 writes 0x11, port 6 writes 0x66 and NZCV writes 4'b1010, all to idx 3. Next cycle: regs[3]=0xA, wr_conflict=1, conflict_count=1.
  - Repeat with NZCV idle: regs[3]=0x66.
- **Scoreboard.**
  - alloc idx 9, then a read → rd_ready=0.
  - Write to idx 9 → rd_ready=1 in that cycle (bypass) and thereafter.
  - alloc and write idx 9 in the same cycle → the next read shows ready=0 and the data updated.
- **Saturation.** CNT_W=2, five consecutive conflict cycles → conflict_count sequence 1,2,3,3,3.
- **Mid-op reset.** Write idx 4 = 0x55 and alloc idx 8, then rst for one cycle → idx 4 reads 0 and idx 8 reads ready=1. With READ_LATENCY=1, the output in the cycle after rst is 0.

Source files
------------

// File: rtl/prf_bypass.sv
// Physical register file with same-cycle write bypass, ready scoreboard and write-conflict tracking.
// Read latency 0 (combinational) or 1 (registered); no backpressure, one read per port per cycle.
module prf_bypass #(
    parameter int WORD_SIZE       = 64,
    parameter int NUM_PHYS_REGS   = 128,
    parameter int NUM_READ_PORTS  = 4,
    parameter int NUM_WRITE_PORTS = 8,
    parameter int NUM_ALLOC_PORTS = 2,
    parameter int READ_LATENCY    = 0,
    parameter int CNT_W           = 16,
    localparam int IDX_W          = $clog2(NUM_PHYS_REGS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_READ_PORTS-1:0]             rd_en,
    input  logic [NUM_READ_PORTS*IDX_W-1:0]       rd_index,
    output logic [NUM_READ_PORTS*WORD_SIZE-1:0]   rd_data,
    output logic [NUM_READ_PORTS-1:0]             rd_ready,
    output logic [NUM_READ_PORTS-1:0]             rd_valid,
    input  logic [NUM_WRITE_PORTS-1:0]            wr_en,
    input  logic [NUM_WRITE_PORTS*IDX_W-1:0]      wr_index,
    input  logic [NUM_WRITE_PORTS*WORD_SIZE-1:0]  wr_data,
    input  logic                                  nzcv_valid,
    input  logic [IDX_W-1:0]                      nzcv_index,
    input  logic [3:0]                            nzcv_data,
    input  logic [NUM_ALLOC_PORTS-1:0]            alloc_en,
    input  logic [NUM_ALLOC_PORTS*IDX_W-1:0]      alloc_index,
    output logic                                  wr_conflict,
    output logic [CNT_W-1:0]                      conflict_count
);

    localparam int NUM_SRC = NUM_WRITE_PORTS + 1;

    // Sources ordered by ascending priority: write ports 0..N-1, then NZCV last.
    logic                 w_src_vld [NUM_SRC];
    logic [IDX_W-1:0]     w_src_idx [NUM_SRC];
    logic [WORD_SIZE-1:0] w_src_dat [NUM_SRC];

    logic [WORD_SIZE-1:0] w_regs  [NUM_PHYS_REGS];
    logic                 w_ready [NUM_PHYS_REGS];

    logic                                 w_conflict;
    logic [NUM_READ_PORTS*WORD_SIZE-1:0]  w_rd_data;
    logic [NUM_READ_PORTS-1:0]            w_rd_ready;
    logic [NUM_READ_PORTS-1:0]            w_rd_valid;

    logic                 r_conflict;
    logic [CNT_W-1:0]     r_conflict_cnt;

    always_comb begin
        for (int s = 0; s < NUM_WRITE_PORTS; s++) begin
            w_src_vld[s] = wr_en[s] & ~rst;
            w_src_idx[s] = wr_index[s*IDX_W +: IDX_W];
            w_src_dat[s] = wr_data[s*WORD_SIZE +: WORD_SIZE];
        end
        w_src_vld[NUM_WRITE_PORTS] = nzcv_valid & ~rst;
        w_src_idx[NUM_WRITE_PORTS] = nzcv_index;
        w_src_dat[NUM_WRITE_PORTS] = {{(WORD_SIZE-4){1'b0}}, nzcv_data};
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = i + 1; j < NUM_SRC; j++) begin
                if (w_src_vld[i] && w_src_vld[j] && (w_src_idx[i] == w_src_idx[j])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PHYS_REGS; g++) begin : g_reg
        logic [WORD_SIZE-1:0] r_reg;
        logic                 r_rdy;

        // Later (higher-priority) sources override earlier ones; allocation overrides any write.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_reg <= '0;
                r_rdy <= 1'b1;
            end else begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (w_src_vld[s] && (w_src_idx[s] == IDX_W'(g))) begin
                        r_reg <= w_src_dat[s];
                        r_rdy <= 1'b1;
                    end
                end
                for (int a = 0; a < NUM_ALLOC_PORTS; a++) begin
                    if (alloc_en[a] && (alloc_index[a*IDX_W +: IDX_W] == IDX_W'(g))) begin
                        r_rdy <= 1'b0;
                    end
                end
            end
        end

        assign w_regs[g]  = r_reg;
        assign w_ready[g] = r_rdy;
    end

    always_comb begin
        logic [IDX_W-1:0]     v_idx;
        logic [WORD_SIZE-1:0] v_dat;
        logic                 v_rdy;
        logic                 v_en;
        w_rd_data  = '0;
        w_rd_ready = '0;
        w_rd_valid = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            v_idx = rd_index[p*IDX_W +: IDX_W];
            v_en  = rd_en[p] & ~rst;
            v_dat = w_regs[v_idx];
            v_rdy = w_ready[v_idx];
            for (int s = 0; s < NUM_SRC; s++) begin
                if (w_src_vld[s] && (w_src_idx[s] == v_idx)) begin
                    v_dat = w_src_dat[s];
                    v_rdy = 1'b1;
                end
            end
            w_rd_data[p*WORD_SIZE +: WORD_SIZE] = v_en ? v_dat : '0;
            w_rd_ready[p] = v_en & v_rdy;
            w_rd_valid[p] = v_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            r_conflict <= w_conflict;
            if (w_conflict && (r_conflict_cnt != {CNT_W{1'b1}})) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    assign wr_conflict    = r_conflict;
    assign conflict_count = r_conflict_cnt;

    if (READ_LATENCY == 0) begin : g_lat0
        assign rd_data  = w_rd_data;
        assign rd_ready = w_rd_ready;
        assign rd_valid = w_rd_valid;
    end else if (READ_LATENCY == 1) begin : g_lat1
        logic [NUM_READ_PORTS*WORD_SIZE-1:0] r_rd_data;
        logic [NUM_READ_PORTS-1:0]           r_rd_ready;
        logic [NUM_READ_PORTS-1:0]           r_rd_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_ready <= '0;
                r_rd_valid <= '0;
            end else begin
                r_rd_data  <= w_rd_data;
                r_rd_ready <= w_rd_ready;
                r_rd_valid <= w_rd_valid;
            end
        end

        assign rd_data  = r_rd_data;
        assign rd_ready = r_rd_ready;
        assign rd_valid = r_rd_valid;
    end else begin : g_bad_latency
        $error("prf_bypass: READ_LATENCY must be 0 or 1");
    end

endmodule

// File: tb/tb_prf_bypass.sv
// Directed bench: dut_a is combinational-read with a 16-bit counter, dut_b is registered-read with a 2-bit counter.
module tb_prf_bypass;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    rd_en;
    logic [27:0]   rd_index;
    logic [7:0]    wr_en;
    logic [55:0]   wr_index;
    logic [511:0]  wr_data;
    logic          nzcv_valid;
    logic [6:0]    nzcv_index;
    logic [3:0]    nzcv_data;
    logic [1:0]    alloc_en;
    logic [13:0]   alloc_index;

    logic [255:0]  a_rd_data;
    logic [3:0]    a_rd_ready;
    logic [3:0]    a_rd_valid;
    logic          a_wr_conflict;
    logic [15:0]   a_cc;
    logic [255:0]  b_rd_data;
    logic [3:0]    b_rd_ready;
    logic [3:0]    b_rd_valid;
    logic          b_wr_conflict;
    logic [1:0]    b_cc;

    int errors;
    int checks;

    always #5 clk = ~clk;

    prf_bypass #(.READ_LATENCY(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_index(rd_index),
        .rd_data(a_rd_data), .rd_ready(a_rd_ready), .rd_valid(a_rd_valid),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .nzcv_valid(nzcv_valid), .nzcv_index(nzcv_index), .nzcv_data(nzcv_data),
        .alloc_en(alloc_en), .alloc_index(alloc_index),
        .wr_conflict(a_wr_conflict), .conflict_count(a_cc)
    );

    prf_bypass #(.READ_LATENCY(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_index(rd_index),
        .rd_data(b_rd_data), .rd_ready(b_rd_ready), .rd_valid(b_rd_valid),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .nzcv_valid(nzcv_valid), .nzcv_index(nzcv_index), .nzcv_data(nzcv_data),
        .alloc_en(alloc_en), .alloc_index(alloc_index),
        .wr_conflict(b_wr_conflict), .conflict_count(b_cc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rd_en = '0; rd_index = '0;
        wr_en = '0; wr_index = '0; wr_data = '0;
        nzcv_valid = 1'b0; nzcv_index = '0; nzcv_data = '0;
        alloc_en = '0; alloc_index = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic rd(input int p, input logic [6:0] idx);
        rd_en[p] = 1'b1;
        rd_index[p*7 +: 7] = idx;
    endtask

    task automatic wr(input int p, input logic [6:0] idx, input logic [63:0] dat);
        wr_en[p] = 1'b1;
        wr_index[p*7 +: 7] = idx;
        wr_data[p*64 +: 64] = dat;
    endtask

    task automatic al(input int p, input logic [6:0] idx);
        alloc_en[p] = 1'b1;
        alloc_index[p*7 +: 7] = idx;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset defaults
        rd(0, 7'd5);
        #1;
        chk("rst_a_data", a_rd_data[63:0], 64'h0);
        chk("rst_a_ready", a_rd_ready[0], 1);
        chk("rst_a_valid", a_rd_valid[0], 1);
        chk("rst_a_cnt", a_cc, 0);
        chk("rst_a_conflict", a_wr_conflict, 0);
        chk("rst_b_valid", b_rd_valid[0], 0);
        chk("rst_b_cnt", b_cc, 0);
        tick();
        chk("rst_b_data", b_rd_data[63:0], 64'h0);
        chk("rst_b_ready", b_rd_ready[0], 1);
        chk("rst_b_valid1", b_rd_valid[0], 1);

        // Bypass
        wr(2, 7'd7, 64'hDEAD_BEEF);
        rd(0, 7'd7);
        rd_index[2*7 +: 7] = 7'd7;
        #1;
        chk("byp_a_data", a_rd_data[63:0], 64'hDEAD_BEEF);
        chk("byp_a_ready", a_rd_ready[0], 1);
        chk("dis_a_data", a_rd_data[128 +: 64], 64'h0);
        chk("dis_a_ready", a_rd_ready[2], 0);
        chk("dis_a_valid", a_rd_valid[2], 0);
        tick();
        chk("byp_b_data", b_rd_data[63:0], 64'hDEAD_BEEF);
        chk("byp_b_ready", b_rd_ready[0], 1);
        chk("byp_b_valid", b_rd_valid[0], 1);
        rd(1, 7'd7);
        #1;
        chk("reg_a_data_p1", a_rd_data[64 +: 64], 64'hDEAD_BEEF);

        // Priority with NZCV
        tick();
        wr(1, 7'd3, 64'h11);
        wr(6, 7'd3, 64'h66);
        nzcv_valid = 1'b1; nzcv_index = 7'd3; nzcv_data = 4'b1010;
        rd(3, 7'd3);
        #1;
        chk("pri_byp_a_data", a_rd_data[192 +: 64], 64'hA);
        tick();
        rd(0, 7'd3);
        #1;
        chk("pri_nzcv_data", a_rd_data[63:0], 64'hA);
        chk("pri_a_conflict", a_wr_conflict, 1);
        chk("pri_a_cnt", a_cc, 1);
        chk("pri_b_cnt", b_cc, 1);

        // Priority without NZCV
        tick();
        wr(1, 7'd3, 64'h11);
        wr(6, 7'd3, 64'h66);
        tick();
        rd(0, 7'd3);
        #1;
        chk("pri_p6_data", a_rd_data[63:0], 64'h66);
        chk("pri_p6_conflict", a_wr_conflict, 1);
        chk("pri_p6_cnt", a_cc, 2);
        tick();
        wr(0, 7'd20, 64'h1);
        wr(1, 7'd21, 64'h2);
        chk("idle_conflict", a_wr_conflict, 0);
        tick();
        chk("distinct_conflict", a_wr_conflict, 0);
        chk("distinct_cnt", a_cc, 2);

        // Scoreboard
        al(0, 7'd9);
        tick();
        rd(0, 7'd9);
        #1;
        chk("sb_alloc_ready", a_rd_ready[0], 0);
        wr(4, 7'd9, 64'h99);
        #1;
        chk("sb_byp_ready", a_rd_ready[0], 1);
        chk("sb_byp_data", a_rd_data[63:0], 64'h99);
        tick();
        chk("sb_b_ready", b_rd_ready[0], 1);
        chk("sb_b_data", b_rd_data[63:0], 64'h99);
        rd(0, 7'd9);
        #1;
        chk("sb_after_ready", a_rd_ready[0], 1);
        al(1, 7'd9);
        wr(0, 7'd9, 64'h123);
        #1;
        chk("sb_same_ready", a_rd_ready[0], 1);
        chk("sb_same_data", a_rd_data[63:0], 64'h123);
        tick();
        rd(0, 7'd9);
        #1;
        chk("sb_allocwin_ready", a_rd_ready[0], 0);
        chk("sb_allocwin_data", a_rd_data[63:0], 64'h123);
        tick();
        al(0, 7'd10);
        al(1, 7'd10);
        tick();
        rd(0, 7'd10);
        #1;
        chk("sb_dup_alloc", a_rd_ready[0], 0);

        // Mid-operation reset
        tick();
        wr(0, 7'd4, 64'h55);
        al(0, 7'd8);
        tick();
        rd(0, 7'd4);
        #1;
        chk("mr_pre_data", a_rd_data[63:0], 64'h55);
        rst = 1'b1;
        wr(5, 7'd11, 64'h77);
        al(1, 7'd12);
        #1;
        chk("mr_during_valid", a_rd_valid[0], 0);
        tick();
        rst = 1'b0;
        rd(0, 7'd4);
        rd(1, 7'd8);
        rd(2, 7'd11);
        rd(3, 7'd12);
        #1;
        chk("mr_idx4_data", a_rd_data[63:0], 64'h0);
        chk("mr_idx8_ready", a_rd_ready[1], 1);
        chk("mr_idx11_data", a_rd_data[128 +: 64], 64'h0);
        chk("mr_idx12_ready", a_rd_ready[3], 1);
        chk("mr_b_valid", b_rd_valid[0], 0);
        chk("mr_b_data", b_rd_data[63:0], 64'h0);
        chk("mr_a_cnt", a_cc, 0);
        chk("mr_b_cnt", b_cc, 0);
        tick();
        chk("mr_b_data_next", b_rd_data[63:0], 64'h0);
        chk("mr_b_ready_next", b_rd_ready[0], 1);

        // Counter saturation
        for (int k = 0; k < 5; k++) begin
            wr(0, 7'd20, 64'h1);
            wr(1, 7'd20, 64'h2);
            tick();
            chk($sformatf("sat_b_cnt%0d", k), b_cc, (k < 2) ? k + 1 : 3);
            chk($sformatf("sat_a_cnt%0d", k), a_cc, k + 1);
            chk($sformatf("sat_b_conflict%0d", k), b_wr_conflict, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
